defuse_array_scanner: RTL and testbench
=======================================

DEFUSE_ARRAY_SCANNER -- requirements
Module: defuse_array_scanner

Interface
REQ-001 SHALL have parameters: none; the board sizes are fixed: easy 8x8, medium 10x10, hard 16x16.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port level, input, 2 bits: 1 = easy, 2 = medium, 3 = hard, 0 = no game.
REQ-005 SHALL have port start, input, 1 bit: request a full-board scan.
REQ-006 SHALL have ports mine_arr_easy/medium/hard, input, [7:0][7:0] / [9:0][9:0] / [15:0][15:0]: mine maps, arr[y][x], 0-based, 1 = mine.
REQ-007 SHALL have ports defuse_arr_easy/medium/hard, input, same widths: defuse maps, arr[y][x], 1 = defused field.
REQ-008 SHALL have port busy, output, 1 bit: high while a scan is in progress or completing.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when the results are valid.
REQ-010 SHALL have ports defused_cnt and mine_cnt, output, 9 bits each: number of defused fields and number of mines on the active board.
REQ-011 SHALL have port mine_hit, output, 1 bit: a field that is both mined and defused exists.
REQ-012 SHALL have ports hit_x and hit_y, output, 5 bits each: 1-based coordinates of the first hit field in scan order.
REQ-013 SHALL have port board_cleared, output, 1 bit: win flag.

Function
REQ-014 SHALL implement the FSM IDLE -> SCAN -> DONE -> IDLE; busy = (state != IDLE).
REQ-015 In IDLE with start=1 and level!=0, SHALL on that edge do all of the following:
- snapshot level and the three arrays of that level into internal registers;
- clear defused_cnt, mine_cnt, mine_hit, hit_x, hit_y and board_cleared;
- set x = y = 0;
- enter SCAN.
REQ-016 SHALL ignore start when level==0, when busy==1, and while in DONE.
REQ-017 In SCAN, SHALL process exactly one cell (x,y) of the snapshot per edge, with x incrementing 0..N-1 and then wrapping to 0 with y+1 (N = 8, 10 or 16).
REQ-018 Per processed cell:
- defused_cnt += defuse bit;
- mine_cnt += mine bit;
- if mine&defuse and mine_hit==0: set mine_hit=1, hit_x=x+1, hit_y=y+1.
REQ-019 Later hits SHALL NOT overwrite hit_x and hit_y.
REQ-020 SHALL enter DONE on the edge that processes cell (N-1,N-1); that same edge SHALL register board_cleared = !mine_hit_final && (defused_cnt_final + mine_cnt_final == N*N).
REQ-021 done SHALL be high only while in DONE, i.e. for exactly one cycle; DONE SHALL return to IDLE on the next edge.
REQ-022 Latency: with start sampled at edge k, done SHALL be high in the cycle between edges k+N*N and k+N*N+1 (easy 64, medium 100, hard 256).
REQ-023 Input array or level changes during SCAN SHALL NOT affect results, because the scan uses the snapshot.
REQ-024 Results SHALL hold after done until the next accepted start.
REQ-025 Counters SHALL be 9 bits wide; a count of 256 SHALL be representable without wrap.

Reset
REQ-026 While rst=1, SHALL force state to IDLE and drive busy, done, defused_cnt, mine_cnt, mine_hit, hit_x, hit_y and board_cleared to 0.
REQ-027 Reset mid-scan SHALL abort the scan: no done pulse, outputs 0, and the next start is accepted normally.
REQ-028 rst SHALL take priority over a simultaneous start.

Verification
REQ-029 Easy board, no mines, all defused, start pulse -> done 64 edges after start; defused_cnt=64, mine_cnt=0, mine_hit=0, board_cleared=1.
REQ-030 Medium board, mines at [2][3] and [9][9], defused at [2][3] and [9][9] -> mine_hit=1, hit_x=4, hit_y=3, board_cleared=0, done after 100 edges.
REQ-031 Hard board, 40 mines, the 216 other fields defused -> defused_cnt=216, mine_cnt=40, board_cleared=1, done after 256 edges; same board with one field left undefused -> board_cleared=0.
REQ-032 Start re-pulsed mid-scan, and defuse array toggled mid-scan -> exactly one done, and results equal those of the original snapshot.
REQ-033 rst asserted at scan cycle 30 of easy -> busy=0 on the next cycle, no done, all outputs 0; start with level=0 -> busy stays 0.

Source files
------------

// File: rtl/defuse_array_scanner.sv
// Full-board defuse scanner: snapshots the board selected by `level`, walks it
// one cell per clock in row-major order, and reports defused/mine counts, the
// first mined-and-defused cell (1-based) and a board-cleared flag.
module defuse_array_scanner (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          level,
  input  logic                start,
  input  logic [7:0][7:0]     mine_arr_easy,
  input  logic [9:0][9:0]     mine_arr_medium,
  input  logic [15:0][15:0]   mine_arr_hard,
  input  logic [7:0][7:0]     defuse_arr_easy,
  input  logic [9:0][9:0]     defuse_arr_medium,
  input  logic [15:0][15:0]   defuse_arr_hard,
  output logic                busy,
  output logic                done,
  output logic [8:0]          defused_cnt,
  output logic [8:0]          mine_cnt,
  output logic                mine_hit,
  output logic [4:0]          hit_x,
  output logic [4:0]          hit_y,
  output logic                board_cleared
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  // Snapshot is always held as a 16x16 map; smaller boards occupy the
  // low corner and the rest stays zero.
  logic [15:0][15:0] snap_mine;
  logic [15:0][15:0] snap_defuse;
  logic [15:0][15:0] load_mine;
  logic [15:0][15:0] load_defuse;
  logic [1:0]        snap_level;

  logic [3:0]        x;
  logic [3:0]        y;
  logic [3:0]        last;
  logic [9:0]        area;
  logic              accept;
  logic              cell_mine;
  logic              cell_def;
  logic              cell_hit;
  logic              last_cell;
  logic [9:0]        total_final;
  logic              cleared_final;

  assign accept    = (state == IDLE) && start && (level != 2'd0);
  assign cell_mine = snap_mine[y][x];
  assign cell_def  = snap_defuse[y][x];
  assign cell_hit  = cell_mine & cell_def;
  assign last_cell = (x == last) && (y == last);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Board geometry of the snapshotted level
  always_comb begin
    last = 4'd15;
    area = 10'd256;
    case (snap_level)
      2'd1: begin
        last = 4'd7;
        area = 10'd64;
      end
      2'd2: begin
        last = 4'd9;
        area = 10'd100;
      end
      default: begin
        last = 4'd15;
        area = 10'd256;
      end
    endcase
  end

  // Final totals include the cell processed on the last edge
  always_comb begin
    total_final   = {1'b0, defused_cnt} + {9'b0, cell_def}
                  + {1'b0, mine_cnt} + {9'b0, cell_mine};
    cleared_final = !(mine_hit | cell_hit) && (total_final == area);
  end

  // Select and zero-pad the live arrays of the requested level
  always_comb begin
    load_mine   = '0;
    load_defuse = '0;
    case (level)
      2'd1: begin
        for (int unsigned r = 0; r < 8; r++) begin
          for (int unsigned c = 0; c < 8; c++) begin
            load_mine[r][c]   = mine_arr_easy[r][c];
            load_defuse[r][c] = defuse_arr_easy[r][c];
          end
        end
      end
      2'd2: begin
        for (int unsigned r = 0; r < 10; r++) begin
          for (int unsigned c = 0; c < 10; c++) begin
            load_mine[r][c]   = mine_arr_medium[r][c];
            load_defuse[r][c] = defuse_arr_medium[r][c];
          end
        end
      end
      2'd3: begin
        load_mine   = mine_arr_hard;
        load_defuse = defuse_arr_hard;
      end
      default: begin
        load_mine   = '0;
        load_defuse = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SCAN;
      SCAN:    if (last_cell) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Snapshot capture, cell walk and result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_level    <= '0;
      x             <= '0;
      y             <= '0;
      defused_cnt   <= '0;
      mine_cnt      <= '0;
      mine_hit      <= 1'b0;
      hit_x         <= '0;
      hit_y         <= '0;
      board_cleared <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            snap_level    <= level;
            snap_mine     <= load_mine;
            snap_defuse   <= load_defuse;
            x             <= '0;
            y             <= '0;
            defused_cnt   <= '0;
            mine_cnt      <= '0;
            mine_hit      <= 1'b0;
            hit_x         <= '0;
            hit_y         <= '0;
            board_cleared <= 1'b0;
          end
        end
        SCAN: begin
          defused_cnt <= defused_cnt + {8'b0, cell_def};
          mine_cnt    <= mine_cnt + {8'b0, cell_mine};
          if (cell_hit && !mine_hit) begin
            mine_hit <= 1'b1;
            hit_x    <= {1'b0, x} + 5'd1;
            hit_y    <= {1'b0, y} + 5'd1;
          end
          if (x == last) begin
            x <= '0;
            y <= y + 4'd1;
          end else begin
            x <= x + 4'd1;
          end
          if (last_cell) board_cleared <= cleared_final;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_defuse_array_scanner.sv
// Randomised self-checking bench for defuse_array_scanner with a loop-based
// reference model of the counting/hit/clear rules.
module tb_defuse_array_scanner;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        level;
  logic              start;
  logic [7:0][7:0]   mine_arr_easy, defuse_arr_easy;
  logic [9:0][9:0]   mine_arr_medium, defuse_arr_medium;
  logic [15:0][15:0] mine_arr_hard, defuse_arr_hard;
  logic              busy, done, mine_hit, board_cleared;
  logic [8:0]        defused_cnt, mine_cnt;
  logic [4:0]        hit_x, hit_y;

  int n_checks = 0;
  int n_fail   = 0;

  bit [15:0][15:0] bm, bd;
  int exp_d, exp_m, exp_hit, exp_hx, exp_hy, exp_clr;

  always #5 clk = ~clk;

  defuse_array_scanner dut (
    .clk(clk), .rst(rst), .level(level), .start(start),
    .mine_arr_easy(mine_arr_easy), .mine_arr_medium(mine_arr_medium),
    .mine_arr_hard(mine_arr_hard), .defuse_arr_easy(defuse_arr_easy),
    .defuse_arr_medium(defuse_arr_medium), .defuse_arr_hard(defuse_arr_hard),
    .busy(busy), .done(done), .defused_cnt(defused_cnt), .mine_cnt(mine_cnt),
    .mine_hit(mine_hit), .hit_x(hit_x), .hit_y(hit_y),
    .board_cleared(board_cleared)
  );

  function automatic int side(input int lvl);
    return (lvl == 1) ? 8 : (lvl == 2) ? 10 : 16;
  endfunction

  // Reference: count fields, find first hit in row-major order, judge win
  task automatic model(input int lvl);
    int n;
    n = side(lvl);
    exp_d = 0; exp_m = 0; exp_hit = 0; exp_hx = 0; exp_hy = 0;
    for (int yy = 0; yy < n; yy++)
      for (int xx = 0; xx < n; xx++) begin
        exp_d += int'(bd[yy][xx]);
        exp_m += int'(bm[yy][xx]);
        if (bm[yy][xx] && bd[yy][xx] && exp_hit == 0) begin
          exp_hit = 1; exp_hx = xx + 1; exp_hy = yy + 1;
        end
      end
    exp_clr = (exp_hit == 0 && exp_d + exp_m == n * n) ? 1 : 0;
  endtask

  // Board of the chosen level goes to its ports; other levels get noise
  task automatic drive_ports(input int lvl);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        if (r < 8 && c < 8) begin
          mine_arr_easy[r][c]   = (lvl == 1) ? bm[r][c] : 1'($urandom);
          defuse_arr_easy[r][c] = (lvl == 1) ? bd[r][c] : 1'($urandom);
        end
        if (r < 10 && c < 10) begin
          mine_arr_medium[r][c]   = (lvl == 2) ? bm[r][c] : 1'($urandom);
          defuse_arr_medium[r][c] = (lvl == 2) ? bd[r][c] : 1'($urandom);
        end
        mine_arr_hard[r][c]   = (lvl == 3) ? bm[r][c] : 1'($urandom);
        defuse_arr_hard[r][c] = (lvl == 3) ? bd[r][c] : 1'($urandom);
      end
  endtask

  // kind 0: random density; 1: winnable (mine xor defused); 2: winnable plus one hit
  task automatic random_board(input int lvl, input int kind);
    int n, r, c;
    n = side(lvl);
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++) begin
        if (kind == 0) begin
          bm[yy][xx] = ($urandom_range(0, 3) == 0);
          bd[yy][xx] = ($urandom_range(0, 1) == 0);
        end else begin
          bm[yy][xx] = ($urandom_range(0, 4) == 0);
          bd[yy][xx] = !bm[yy][xx];
        end
      end
    if (kind == 2) begin
      r = $urandom_range(0, n - 1); c = $urandom_range(0, n - 1);
      bm[r][c] = 1'b1; bd[r][c] = 1'b1;
    end
  endtask

  // Pulse start for one edge; returns in the cycle right after that edge
  task automatic pulse_start(input int lvl);
    @(negedge clk); level = 2'(lvl); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Cycles after the start edge until done is seen; -1 on timeout
  task automatic wait_done(input int n, output int lat);
    lat = -1;
    for (int c = 1; c <= n * n + 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = c; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; level = 2'd1;
    bm = '0; bd = '0; drive_ports(1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_done: busy=%b done=%b required 0 0", busy, done);
    end
    n_checks++;
    if (defused_cnt !== 9'd0 || mine_cnt !== 9'd0 || mine_hit !== 1'b0 ||
        hit_x !== 5'd0 || hit_y !== 5'd0 || board_cleared !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: d=%0d m=%0d hit=%b hx=%0d hy=%0d clr=%b required all 0",
               defused_cnt, mine_cnt, mine_hit, hit_x, hit_y, board_cleared);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_priority: busy=%b required 0", busy);
    end
  endtask

  task automatic test_easy_clear;
    int lat;
    bm = '0; bd = '1; drive_ports(1);
    pulse_start(1);
    wait_done(8, lat);
    n_checks++;
    if (lat != 64) begin
      n_fail++;
      $display("FAIL easy_latency: got %0d required 64", lat);
    end
    n_checks++;
    if (defused_cnt !== 9'd64 || mine_cnt !== 9'd0 || mine_hit !== 1'b0 || board_cleared !== 1'b1) begin
      n_fail++;
      $display("FAIL easy_results: d=%0d m=%0d hit=%b clr=%b required 64 0 0 1",
               defused_cnt, mine_cnt, mine_hit, board_cleared);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL easy_done_width: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_medium_hit;
    int lat;
    bm = '0; bd = '0;
    bm[2][3] = 1'b1; bm[9][9] = 1'b1; bd[2][3] = 1'b1; bd[9][9] = 1'b1;
    drive_ports(2);
    pulse_start(2);
    wait_done(10, lat);
    n_checks++;
    if (lat != 100) begin
      n_fail++;
      $display("FAIL medium_latency: got %0d required 100", lat);
    end
    n_checks++;
    if (mine_hit !== 1'b1 || hit_x !== 5'd4 || hit_y !== 5'd3 || board_cleared !== 1'b0) begin
      n_fail++;
      $display("FAIL medium_hit: hit=%b hx=%0d hy=%0d clr=%b required 1 4 3 0",
               mine_hit, hit_x, hit_y, board_cleared);
    end
    n_checks++;
    if (defused_cnt !== 9'd2 || mine_cnt !== 9'd2) begin
      n_fail++;
      $display("FAIL medium_counts: d=%0d m=%0d required 2 2", defused_cnt, mine_cnt);
    end
  endtask

  task automatic test_hard_board;
    int lat, placed, r, c;
    bm = '0; bd = '1; placed = 0;
    while (placed < 40) begin
      r = $urandom_range(0, 15); c = $urandom_range(0, 15);
      if (!bm[r][c]) begin bm[r][c] = 1'b1; bd[r][c] = 1'b0; placed++; end
    end
    drive_ports(3);
    pulse_start(3);
    wait_done(16, lat);
    n_checks++;
    if (lat != 256) begin
      n_fail++;
      $display("FAIL hard_latency: got %0d required 256", lat);
    end
    n_checks++;
    if (defused_cnt !== 9'd216 || mine_cnt !== 9'd40 || board_cleared !== 1'b1 || mine_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL hard_clear: d=%0d m=%0d clr=%b hit=%b required 216 40 1 0",
               defused_cnt, mine_cnt, board_cleared, mine_hit);
    end
    // leave the first defused field undefused
    begin
      bit found;
      found = 0;
      for (int yy = 0; yy < 16; yy++)
        for (int xx = 0; xx < 16; xx++)
          if (!found && bd[yy][xx]) begin bd[yy][xx] = 1'b0; found = 1; end
    end
    drive_ports(3);
    pulse_start(3);
    wait_done(16, lat);
    n_checks++;
    if (lat != 256 || defused_cnt !== 9'd215 || board_cleared !== 1'b0) begin
      n_fail++;
      $display("FAIL hard_one_left: lat=%0d d=%0d clr=%b required 256 215 0",
               lat, defused_cnt, board_cleared);
    end
  endtask

  task automatic test_random_boards;
    int lvl, lat, n;
    for (int i = 0; i < 12; i++) begin
      lvl = $urandom_range(1, 3);
      random_board(lvl, i % 3);
      drive_ports(lvl);
      model(lvl);
      n = side(lvl);
      pulse_start(lvl);
      wait_done(n, lat);
      n_checks++;
      if (lat != n * n ||
          defused_cnt !== 9'(exp_d) || mine_cnt !== 9'(exp_m) ||
          mine_hit !== 1'(exp_hit) || hit_x !== 5'(exp_hx) || hit_y !== 5'(exp_hy) ||
          board_cleared !== 1'(exp_clr)) begin
        n_fail++;
        $display("FAIL random_%0d lvl%0d: lat=%0d d=%0d m=%0d hit=%b hx=%0d hy=%0d clr=%b required lat=%0d d=%0d m=%0d hit=%0d hx=%0d hy=%0d clr=%0d",
                 i, lvl, lat, defused_cnt, mine_cnt, mine_hit, hit_x, hit_y, board_cleared,
                 n * n, exp_d, exp_m, exp_hit, exp_hx, exp_hy, exp_clr);
      end
      // results hold until the next accepted start
      repeat (3) @(negedge clk);
      n_checks++;
      if (defused_cnt !== 9'(exp_d) || mine_cnt !== 9'(exp_m) || board_cleared !== 1'(exp_clr)) begin
        n_fail++;
        $display("FAIL random_hold_%0d: d=%0d m=%0d clr=%b required %0d %0d %0d",
                 i, defused_cnt, mine_cnt, board_cleared, exp_d, exp_m, exp_clr);
      end
    end
  endtask

  task automatic test_back_to_back;
    int ndone, first;
    random_board(1, 2);
    drive_ports(1);
    model(1);
    pulse_start(1);
    ndone = 0; first = -1;
    for (int c = 1; c <= 90; c++) begin
      if (c == 10) start = 1'b1;
      if (c == 11) start = 1'b0;
      if (c == 20) begin
        bd = ~bd; bm = ~bm; drive_ports(2); level = 2'd3;
      end
      @(negedge clk);
      if (done === 1'b1) begin ndone++; if (first < 0) first = c; end
    end
    n_checks++;
    if (ndone != 1 || first != 64) begin
      n_fail++;
      $display("FAIL midscan_done: pulses=%0d at=%0d required 1 at 64", ndone, first);
    end
    n_checks++;
    if (defused_cnt !== 9'(exp_d) || mine_cnt !== 9'(exp_m) || mine_hit !== 1'(exp_hit) ||
        hit_x !== 5'(exp_hx) || hit_y !== 5'(exp_hy) || board_cleared !== 1'(exp_clr)) begin
      n_fail++;
      $display("FAIL midscan_results: d=%0d m=%0d hit=%b hx=%0d hy=%0d clr=%b required %0d %0d %0d %0d %0d %0d",
               defused_cnt, mine_cnt, mine_hit, hit_x, hit_y, board_cleared,
               exp_d, exp_m, exp_hit, exp_hx, exp_hy, exp_clr);
    end
  endtask

  task automatic test_reset_midscan;
    int ndone, lat;
    random_board(1, 0);
    drive_ports(1);
    pulse_start(1);
    ndone = 0;
    for (int c = 1; c < 30; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || defused_cnt !== 9'd0 || mine_cnt !== 9'd0 ||
        mine_hit !== 1'b0 || hit_x !== 5'd0 || hit_y !== 5'd0 || board_cleared !== 1'b0) begin
      n_fail++;
      $display("FAIL midscan_reset: busy=%b done=%b d=%0d m=%0d hit=%b hx=%0d hy=%0d clr=%b required all 0",
               busy, done, defused_cnt, mine_cnt, mine_hit, hit_x, hit_y, board_cleared);
    end
    rst = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    n_checks++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL midscan_reset_no_done: pulses=%0d required 0", ndone);
    end
    random_board(1, 1);
    drive_ports(1);
    model(1);
    pulse_start(1);
    wait_done(8, lat);
    n_checks++;
    if (lat != 64 || defused_cnt !== 9'(exp_d) || board_cleared !== 1'(exp_clr)) begin
      n_fail++;
      $display("FAIL after_reset_scan: lat=%0d d=%0d clr=%b required 64 %0d %0d",
               lat, defused_cnt, board_cleared, exp_d, exp_clr);
    end
  endtask

  task automatic test_level_zero;
    int busy_seen;
    pulse_start(0);
    busy_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (busy !== 1'b0) busy_seen++;
      @(negedge clk);
    end
    n_checks++;
    if (busy_seen != 0) begin
      n_fail++;
      $display("FAIL level_zero: busy cycles=%0d required 0", busy_seen);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; level = 2'd0;
    test_reset();
    test_easy_clear();
    test_medium_hit();
    test_hard_board();
    test_random_boards();
    test_back_to_back();
    test_reset_midscan();
    test_level_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
